// File: rtl/envelope_scaler.sv
// Scales a signed sample by an envelope coefficient in hundredths: sample * mag / FULL_SCALE.
// Shift-add multiply followed by restoring divide, fixed latency, valid/ready on both sides.
module envelope_scaler #(
  parameter int SAMPLE_W   = 16,
  parameter int MAG_W      = 8,
  parameter int FULL_SCALE = 100
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [MAG_W-1:0]    magnitude,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                busy
);

  localparam int PROD_W = SAMPLE_W + 1 + MAG_W;
  localparam int CNT_W  = $clog2(PROD_W + 1);
  // Remainder is always below FULL_SCALE; one extra bit holds the shifted trial value.
  localparam int REM_W  = $clog2(2 * FULL_SCALE);

  localparam logic [MAG_W-1:0] FS_MAG = MAG_W'(FULL_SCALE);
  localparam logic [REM_W-1:0] FS_REM = REM_W'(FULL_SCALE);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MAG_W);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(PROD_W);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t               state_reg, state_next;
  logic                 sign_reg, sign_next;
  logic [MAG_W-1:0]     mag_reg, mag_next;
  logic [PROD_W-1:0]    mcand_reg, mcand_next;
  logic [PROD_W-1:0]    acc_reg, acc_next;
  logic [REM_W-1:0]     rem_reg, rem_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 out_valid_reg, out_valid_next;
  logic [SAMPLE_W-1:0]  sample_out_reg, sample_out_next;

  logic [SAMPLE_W:0]    abs_in;
  logic [REM_W-1:0]     trial;
  logic                 qbit;
  logic [SAMPLE_W-1:0]  q_low;

  // Widen before negating so that the most negative sample has a representable magnitude.
  always_comb begin
    abs_in = {sample_in[SAMPLE_W-1], sample_in};
    if (sample_in[SAMPLE_W-1])
      abs_in = ~abs_in + 1'b1;
  end

  assign trial = {rem_reg[REM_W-2:0], acc_reg[PROD_W-1]};
  assign qbit  = (trial >= FS_REM);
  assign q_low = {acc_reg[SAMPLE_W-2:0], qbit};

  always_comb begin
    state_next      = state_reg;
    sign_next       = sign_reg;
    mag_next        = mag_reg;
    mcand_next      = mcand_reg;
    acc_next        = acc_reg;
    rem_next        = rem_reg;
    cnt_next        = cnt_reg;
    out_valid_next  = out_valid_reg;
    sample_out_next = sample_out_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next  = sample_in[SAMPLE_W-1];
          mag_next   = (magnitude > FS_MAG) ? FS_MAG : magnitude;
          mcand_next = {{MAG_W{1'b0}}, abs_in};
          acc_next   = '0;
          cnt_next   = CNT_MUL;
          state_next = MUL;
        end
      end
      MUL: begin
        if (mag_reg[0])
          acc_next = acc_reg + mcand_reg;
        mag_next   = mag_reg >> 1;
        mcand_next = mcand_reg << 1;
        cnt_next   = cnt_reg - 1'b1;
        if (cnt_reg == CNT_ONE) begin
          rem_next   = '0;
          cnt_next   = CNT_DIV;
          state_next = DIV;
        end
      end
      DIV: begin
        // Product bits leave from the top of acc while quotient bits enter at the bottom.
        rem_next = qbit ? (trial - FS_REM) : trial;
        acc_next = {acc_reg[PROD_W-2:0], qbit};
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_ONE) begin
          sample_out_next = sign_reg ? (~q_low + 1'b1) : q_low;
          out_valid_next  = 1'b1;
          state_next      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= IDLE;
      sign_reg       <= 1'b0;
      mag_reg        <= '0;
      mcand_reg      <= '0;
      acc_reg        <= '0;
      rem_reg        <= '0;
      cnt_reg        <= '0;
      out_valid_reg  <= 1'b0;
      sample_out_reg <= '0;
    end else begin
      state_reg      <= state_next;
      sign_reg       <= sign_next;
      mag_reg        <= mag_next;
      mcand_reg      <= mcand_next;
      acc_reg        <= acc_next;
      rem_reg        <= rem_next;
      cnt_reg        <= cnt_next;
      out_valid_reg  <= out_valid_next;
      sample_out_reg <= sample_out_next;
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign out_valid  = out_valid_reg;
  assign sample_out = sample_out_reg;

endmodule

// File: tb/tb_envelope_scaler.sv
// Directed and random checks of envelope_scaler against an integer-arithmetic reference.
module tb_envelope_scaler;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] sample_in = '0;
  logic [7:0]  magnitude = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [15:0] sample_out;

  int checks = 0;
  int failures = 0;

  envelope_scaler dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sample_in  (sample_in),
    .magnitude  (magnitude),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sample_out (sample_out),
    .busy       (busy)
  );

  always #5 Clk = ~Clk;

  // SV integer division truncates toward zero, which is the required rounding.
  function automatic int model(input int s, input int m);
    int mc;
    mc = (m > 100) ? 100 : m;
    return (s * mc) / 100;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input int s, input int m, input int hold, input string tag);
    logic [15:0] exp16;
    logic [15:0] r;
    int lat;
    exp16 = 16'(model(s, m));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    sample_in = 16'(s);
    magnitude = 8'(m);
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    r = 16'($urandom);
    sample_in = r;
    magnitude = 8'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd33);
    check({tag, "_result"}, 32'(sample_out), 32'(exp16));
    $display("op %s sample=%0d mag=%0d -> out=%0d lat=%0d", tag, s, m, $signed(sample_out), lat);
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      r = 16'($urandom);
      sample_in = r;
      magnitude = 8'($urandom);
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_data"}, 32'(sample_out), 32'(exp16));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_again"}, 32'(in_ready), 32'd1);
    check({tag, "_out_kept"}, 32'(sample_out), 32'(exp16));
    tick();
    check({tag, "_nothing_accepted"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] r;
    int seen;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sample_out", 32'(sample_out), 32'd0);

    run_op(1000, 50, 0, "nominal_50");
    run_op(1000, 3, 0, "nominal_3");
    run_op(32767, 100, 0, "max_pos");
    run_op(-32768, 100, 0, "max_neg");
    run_op(32767, 255, 0, "clamp");
    run_op(-12345, 0, 0, "mag_zero");
    run_op(7, 50, 0, "trunc_pos");
    run_op(-7, 50, 0, "trunc_neg");
    run_op(-1, 99, 0, "trunc_m1");
    run_op(-2000, 37, 10, "backpressure");

    // Abort mid-division; the aborted result must never surface.
    sample_in = 16'd1234;
    magnitude = 8'd77;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    repeat (14) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sample_out", 32'(sample_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_op(-4321, 64, 0, "after_abort");

    for (int i = 0; i < 20; i++) begin
      r = 16'($urandom);
      run_op(int'($signed(r)), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/envelope_scaler.md
Name: envelope_scaler

Overview:
Consumer end of the envelope path. It takes one signed operator sample and the 8-bit envelope magnitude, which is a coefficient in hundredths where 100 means unity. It returns sample * magnitude / FULL_SCALE through a valid/ready handshake.
The multiply is a sequential shift-add and the divide is a sequential restoring divider, so no hard multiplier or divider is used. It sits between each operator's sample output and the voice mixer.

Parameters:
SAMPLE_W, 16, width of signed input and output samples
MAG_W, 8, width of the unsigned envelope magnitude
FULL_SCALE, 100, magnitude value meaning unity gain; also the divisor

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
in_valid  input  1  sample_in and magnitude are valid
in_ready  output  1  block can accept a new operand pair
sample_in  input  SAMPLE_W  signed two's-complement operator sample
magnitude  input  MAG_W  unsigned envelope coefficient, nominal range 0..FULL_SCALE
out_valid  output  1  sample_out holds a completed result
out_ready  input  1  downstream accepts the result
sample_out  output  SAMPLE_W  signed scaled sample
busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock, Clk. Reset is synchronous and active-high.
- Outputs after any Reset edge:
  - state = IDLE
  - out_valid = 0
  - sample_out = 0
  - busy = 0
  - in_ready = 1
- in_ready is decoded from state: 1 only in IDLE.
- States: IDLE, MUL, DIV, DONE. Define PROD_W = SAMPLE_W + 1 + MAG_W (25 by default).
- IDLE:
  - On an edge with in_valid && in_ready, capture sign = sample_in[MSB] and abs = |sample_in| as a (SAMPLE_W+1)-bit value, so -32768 becomes 32768.
  - Capture mag = min(magnitude, FULL_SCALE); values above FULL_SCALE are clamped.
  - Clear the accumulator and load bit counter = MAG_W. Go to MUL.
- MUL: one magnitude bit per edge, LSB first.
  - If the current bit is 1, acc += abs << bit index.
  - After exactly MAG_W edges, acc holds the PROD_W-bit product. Load the divider with remainder = 0 and count = PROD_W. Go to DIV.
- DIV: restoring division by FULL_SCALE, one quotient bit per edge, MSB first.
  - rem = {rem, next product bit}.
  - If rem >= FULL_SCALE: subtract FULL_SCALE and shift in quotient bit 1; otherwise shift in 0.
  - After exactly PROD_W edges, form the result: quotient if sign = 0, two's-complement negation of quotient if sign = 1. Truncate to SAMPLE_W.
  - Register the result into sample_out, set out_valid = 1, go to DONE.
- Result rules:
  - The quotient never exceeds 2^(SAMPLE_W-1) because mag <= FULL_SCALE, so no saturation logic is needed.
  - Rounding is toward zero.
- Fixed latency: if the accept edge is E, out_valid first reads 1 after edge E + MAG_W + PROD_W, which is E+33 by default.
  - Latency is identical for every operand, including magnitude 0 and FULL_SCALE; there are no fast paths.
- DONE:
  - sample_out and out_valid hold stable until an edge with out_ready = 1.
  - On that edge, out_valid goes to 0 and state goes to IDLE. in_ready is 1 from the following cycle.
  - sample_out keeps its last value after the handshake.
  - Accepting a new input takes at least one IDLE cycle, so inputs are never accepted in DONE.
- Operand stability: changes on sample_in or magnitude after the accept edge have no effect on the result in flight. in_valid outside IDLE is ignored.
- Throughput: one result per MAG_W + PROD_W + 2 cycles, minimum.
- Reset mid-operation (MUL, DIV or DONE): abort on that edge and return to the reset values. The aborted result is never presented.

Test Plan:
- Idle after reset: hold Reset 2 cycles -> in_ready=1, out_valid=0, busy=0, sample_out=0.
- Nominal scaling: sample_in=1000, magnitude=50 accepted at edge E -> out_valid rises after E+33, sample_out=500. Also sample_in=1000, magnitude=3 -> 30.
- Extremes and clamp:
  - sample_in=32767, magnitude=100 -> 32767.
  - sample_in=-32768, magnitude=100 -> -32768.
  - sample_in=32767, magnitude=255 -> 32767 (clamped to 100).
  - magnitude=0 with any sample -> 0, with latency still 33.
- Truncation toward zero: sample_in=7, magnitude=50 -> 3; sample_in=-7, magnitude=50 -> -3; sample_in=-1, magnitude=99 -> 0.
- Backpressure: keep out_ready=0 for 10 cycles after out_valid rises, pulsing in_valid with new operands and changing sample_in -> sample_out and out_valid stay stable, in_ready=0, nothing is accepted. Raise out_ready -> out_valid=0 on the next edge, then in_ready=1.
- Reset abort: assert Reset for one edge 15 cycles after accept (state DIV) -> IDLE next cycle and out_valid never rises for that operand. A new operand accepted afterwards produces the correct result after 33 edges.
